// File: rtl/tdm_demux4.sv
// Time-division demultiplexer: steers a serial sample stream into four lane
// registers, aligned to a slot-0 frame marker, and publishes whole frames only.
module tdm_demux4 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         en,
  input  logic         sync,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic         frame_valid,
  output logic         locked,
  output logic         sync_err,
  output logic [1:0]   slot
);

  localparam int unsigned SLOT_W = 2;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SLOT_W-1:0] r_slot;
  logic [SLOT_W-1:0] w_slot_nxt;
  logic [W-1:0]      r_sh0, r_sh1, r_sh2;
  logic [W-1:0]      w_sh0_nxt, w_sh1_nxt, w_sh2_nxt;
  logic [W-1:0]      r_y0, r_y1, r_y2, r_y3;
  logic [W-1:0]      w_y0_nxt, w_y1_nxt, w_y2_nxt, w_y3_nxt;
  logic              r_frame_valid, w_frame_valid_nxt;
  logic              r_sync_err, w_sync_err_nxt;
  logic              r_locked;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, slot steering and frame publication
  always_comb begin
    w_state_nxt       = r_state;
    w_slot_nxt        = r_slot;
    w_sh0_nxt         = r_sh0;
    w_sh1_nxt         = r_sh1;
    w_sh2_nxt         = r_sh2;
    w_y0_nxt          = r_y0;
    w_y1_nxt          = r_y1;
    w_y2_nxt          = r_y2;
    w_y3_nxt          = r_y3;
    w_frame_valid_nxt = 1'b0;
    w_sync_err_nxt    = 1'b0;

    if (en) begin
      case (r_state)
        HUNT: begin
          if (sync) begin
            w_sh0_nxt   = din;
            w_slot_nxt  = SLOT_W'(1);
            w_state_nxt = LOCK;
          end
        end
        LOCK: begin
          if (sync && (r_slot != '0)) begin
            // Marker mid-frame: drop the partial frame and realign on this sample
            w_sync_err_nxt = 1'b1;
            w_sh0_nxt      = din;
            w_slot_nxt     = SLOT_W'(1);
          end else begin
            case (r_slot)
              2'd0: w_sh0_nxt = din;
              2'd1: w_sh1_nxt = din;
              2'd2: w_sh2_nxt = din;
              default: begin
                // Slot-3 sample goes straight to y3 so the frame lands on this edge
                w_y0_nxt          = r_sh0;
                w_y1_nxt          = r_sh1;
                w_y2_nxt          = r_sh2;
                w_y3_nxt          = din;
                w_frame_valid_nxt = 1'b1;
              end
            endcase
            w_slot_nxt = r_slot + SLOT_W'(1);
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  // Datapath and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot        <= '0;
      r_sh0         <= '0;
      r_sh1         <= '0;
      r_sh2         <= '0;
      r_y0          <= '0;
      r_y1          <= '0;
      r_y2          <= '0;
      r_y3          <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      r_slot        <= w_slot_nxt;
      r_sh0         <= w_sh0_nxt;
      r_sh1         <= w_sh1_nxt;
      r_sh2         <= w_sh2_nxt;
      r_y0          <= w_y0_nxt;
      r_y1          <= w_y1_nxt;
      r_y2          <= w_y2_nxt;
      r_y3          <= w_y3_nxt;
      r_frame_valid <= w_frame_valid_nxt;
      r_sync_err    <= w_sync_err_nxt;
      r_locked      <= (w_state_nxt == LOCK);
    end
  end

  assign y0          = r_y0;
  assign y1          = r_y1;
  assign y2          = r_y2;
  assign y3          = r_y3;
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;
  assign locked      = r_locked;
  assign slot        = r_slot;

endmodule
